fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage: owns the PC, issues word requests to instruction memory, buffers returned instructions, and presents them in order to decode.
- Decode slices `id_instr` into the immediate extender and control unit.
- Supports decode back-pressure, variable-latency in-order memory responses, and branch/jump redirects that discard in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2. Also bounds outstanding requests.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  DATA_WIDTH  fetch address (word aligned)
- imem_resp_valid  in  1  response valid; always accepted, in request order
- imem_resp_data  in  DATA_WIDTH  fetched instruction word
- redirect_valid  in  1  branch/jump taken, from execute
- redirect_pc  in  DATA_WIDTH  new PC
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_instr  out  DATA_WIDTH  instruction word
- id_pc  out  DATA_WIDTH  address of id_instr
- id_pc_plus4  out  DATA_WIDTH  id_pc + 4

Behaviour:
- Reset, asynchronous and active-high:
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0; id_valid = 0; id_instr/id_pc = 0; id_pc_plus4 = 4.
  - Reset asserted mid-operation abandons all state. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Request issue:
  - imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4; outstanding++.
  - Address is combinational from fetch_pc; valid may drop without a handshake; the memory must not rely on valid stability.
- Response:
  - On imem_resp_valid: outstanding--.
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Else: push {imem_resp_data, resp_pc} into the FIFO; resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. A response arriving at a full FIFO is impossible by construction; assert it in simulation.
- Output:
  - id_valid = FIFO not empty; id_instr/id_pc come from the FIFO head.
  - Pop on id_valid && id_ready.
  - Minimum latency: response cycle N → id_valid at N+1.
  - Simultaneous push/pop allowed; count is unchanged.
- Redirect (highest priority, single cycle):
  - FIFO flushed; any pop that cycle is ignored.
  - fetch_pc and resp_pc are set to redirect_pc; no request is issued that cycle.
  - drop_cnt is set to outstanding minus (imem_resp_valid ? 1 : 0), i.e. all remaining in-flight responses. A response arriving in the redirect cycle is itself discarded.
  - If drop_cnt is already nonzero, the same formula applies. outstanding already includes old drops, so the result is consistent.
- Back-to-back redirects: each one fully supersedes the previous.
- Arithmetic: PC increments wrap modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC + 4 = 0. Counters are $clog2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.
- redirect_pc[1:0] are ignored (forced to 0) unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - Adds output id_misaligned (1 bit), carried through the FIFO with each entry.
  - A redirect with redirect_pc[1:0] != 0 issues no memory request. Instead it pushes one entry with instr = 32'h0000_0013 (NOP), pc = redirect_pc, and misaligned = 1.
  - Fetching then halts (imem_req_valid = 0) until the next redirect or reset.
- When undefined: no port; low address bits are forced to zero.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_WIDTH default.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - fetch_entry_t typedef: instr, pc, and misaligned when FETCH_MISALIGN_EN is defined.
- One sub-module: fetch_fifo. A synchronous FIFO of fetch_entry_t with push, pop, flush, count, and empty outputs. Flush has priority over push/pop.
- All PC/credit/drop logic lives in fetch_unit.

Test Plan:
- Reset release, memory with 1-cycle latency, id_ready = 1:
  - Requests go to 0x0, 0x4, 0x8.
  - id_pc sequence 0x0, 0x4, 0x8, with id_pc_plus4 = 0x4, 0x8, 0xC.
  - Throughput is one instruction per cycle after fill.
- id_ready = 0 for 10 cycles:
  - Exactly 4 requests issued (outstanding + count = 4), then imem_req_valid = 0.
  - On id_ready = 1, instructions 0x0–0xC drain in order and fetch resumes at 0x10.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x100:
  - The 3 stale responses are dropped.
  - The next id_valid shows id_pc = 0x100 with the word from 0x100.
- Redirect in the same cycle as a response and a decode pop:
  - FIFO empty next cycle; the arriving response is dropped.
  - No stale PC ever appears on id_pc.
- fetch_pc = 0xFFFF_FFFC: next request address is 0x0000_0000.
- FETCH_MISALIGN_EN, redirect to 0x102:
  - id_misaligned = 1, id_instr = 0x13, id_pc = 0x102.
  - No further requests until a redirect to 0x200 resumes normal fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch buffer entry type.
// FETCH_MISALIGN_EN adds a misaligned flag to every fetch entry.
package cpu_pkg;

   localparam int unsigned               CPU_DATA_WIDTH = 32;
   localparam logic [CPU_DATA_WIDTH-1:0] CPU_RESET_PC   = 32'h0000_0000;
   localparam logic [CPU_DATA_WIDTH-1:0] NOP_INSTR      = 32'h0000_0013;

   typedef struct packed {
      logic [CPU_DATA_WIDTH-1:0] instr;
      logic [CPU_DATA_WIDTH-1:0] pc;
`ifdef FETCH_MISALIGN_EN
      logic                      misaligned;
`endif
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
// Head entry is read combinationally from storage.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  fetch_entry_t           i_data,
   input  logic                   i_pop,
   output fetch_entry_t           o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (i_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!i_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   // Storage needs no reset: empty entries are never presented.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, drops stale responses after redirects.
// Define FETCH_MISALIGN_EN to turn misaligned redirects into a flagged NOP that halts fetch.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned           FIFO_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = CPU_RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic [DATA_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_pc_plus4
`ifdef FETCH_MISALIGN_EN
   ,
   output logic                  id_misaligned
`endif
);

   localparam int unsigned           CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned           SW      = CW + 1;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] r_fetch_pc;
   logic [DATA_WIDTH-1:0] r_resp_pc;
   logic [CW-1:0]         r_outstanding;
   logic [CW-1:0]         r_drop_cnt;
   logic [CW-1:0]         w_count;
   logic                  w_empty;
   logic                  w_req_fire;
   logic                  w_resp_keep;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_halt;
   logic [DATA_WIDTH-1:0] w_redirect_pc;
   fetch_entry_t          w_push_data;
   fetch_entry_t          w_head;

   assign w_redirect_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
   logic                  w_misalign;
   logic                  r_halt;
   logic                  r_nop_pend;
   logic [DATA_WIDTH-1:0] r_nop_pc;

   assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // Misaligned target: queue a flagged NOP for the cycle after the flush, then stop fetching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_halt     <= 1'b0;
         r_nop_pend <= 1'b0;
         r_nop_pc   <= '0;
      end else if (redirect_valid) begin
         r_halt     <= w_misalign;
         r_nop_pend <= w_misalign;
         r_nop_pc   <= redirect_pc;
      end else begin
         r_nop_pend <= 1'b0;
      end
   end

   assign w_halt = r_halt;
`else
   logic w_unused;

   assign w_unused = ^redirect_pc[1:0];
   assign w_halt   = 1'b0;
`endif

   // Credit rule: in-flight requests plus buffered entries never exceed the buffer depth.
   assign imem_req_valid = !rst && !redirect_valid && !w_halt &&
                           ((SW'(r_outstanding) + SW'(w_count)) < SW'(FIFO_DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_resp_keep    = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_pop          = id_valid && id_ready;

`ifdef FETCH_MISALIGN_EN
   assign w_push = w_resp_keep || r_nop_pend;
`else
   assign w_push = w_resp_keep;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_resp_keep)          r_resp_pc  <= r_resp_pc + PC_STEP;
            else if (imem_resp_valid) r_drop_cnt <= r_drop_cnt - CW'(1);
         end
         if (w_req_fire && !imem_resp_valid)      r_outstanding <= r_outstanding + CW'(1);
         else if (!w_req_fire && imem_resp_valid) r_outstanding <= r_outstanding - CW'(1);
      end
   end

   always_comb begin
      w_push_data       = '0;
      w_push_data.instr = imem_resp_data;
      w_push_data.pc    = r_resp_pc;
`ifdef FETCH_MISALIGN_EN
      if (r_nop_pend) begin
         w_push_data.instr      = NOP_INSTR;
         w_push_data.pc         = r_nop_pc;
         w_push_data.misaligned = 1'b1;
      end
`endif
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign id_valid    = !w_empty;
   assign id_instr    = w_empty ? '0 : w_head.instr;
   assign id_pc       = w_empty ? '0 : w_head.pc;
   assign id_pc_plus4 = id_pc + PC_STEP;
`ifdef FETCH_MISALIGN_EN
   assign id_misaligned = !w_empty && w_head.misaligned;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_resp_keep && (w_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: epoch-tagged transaction model predicts requests and the decode stream each cycle.
// Directed phases plus a short randomized handshake phase; literal checks pin the model.
`timescale 1ns/1ps
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_EN
   logic        id_misaligned;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fetch_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_MISALIGN_EN
      , .id_misaligned(id_misaligned)
`endif
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[31:16], a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;

   mreq_t       memq[$];
   exp_t        mfifo[$];
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] pop_ilog[$];
   logic        pop_mlog[$];
   int          epoch;
   int          cyc;
   int          lat;
   logic [31:0] next_req;
   logic        halted;
   logic        nop_pend;
   logic [31:0] nop_pc;
   logic        s_fire, s_pop, s_redir, s_resp;
   logic [31:0] s_addr, s_rpc;

   // Compare DUT outputs against the model mid-cycle and capture the handshakes.
   always @(negedge clk) begin : cmp
      logic exp_rv;
      s_fire = 1'b0; s_pop = 1'b0; s_redir = 1'b0; s_resp = 1'b0;
      if (!rst) begin
         exp_rv = !redirect_valid && !halted && (memq.size() + mfifo.size() < int'(DEPTH));
         check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
         if (exp_rv) check("req_addr", imem_req_addr, next_req);
         check("id_valid", 32'(id_valid), 32'(mfifo.size() != 0));
         if (mfifo.size() != 0) begin
            check("id_pc", id_pc, mfifo[0].pc);
            check("id_instr", id_instr, mfifo[0].instr);
            check("id_pc_plus4", id_pc_plus4, mfifo[0].pc + 32'd4);
`ifdef FETCH_MISALIGN_EN
            check("id_misaligned", 32'(id_misaligned), 32'(mfifo[0].mis));
`endif
         end
         s_fire  = imem_req_valid && imem_req_ready;
         s_addr  = imem_req_addr;
         s_pop   = id_valid && id_ready && !redirect_valid;
         s_redir = redirect_valid;
         s_rpc   = redirect_pc;
         s_resp  = imem_resp_valid;
      end
   end

   // Model update at the clock edge, then the memory drives the next response.
   always @(posedge clk) begin : mdl
      mreq_t r;
      if (rst) begin
         memq.delete(); mfifo.delete();
         epoch = 0; cyc = 0; next_req = 32'h0;
         halted = 1'b0; nop_pend = 1'b0; nop_pc = 32'h0;
      end else begin
         cyc++;
         if (s_pop && mfifo.size() != 0) begin
            pop_log.push_back(mfifo[0].pc);
            pop_ilog.push_back(mfifo[0].instr);
            pop_mlog.push_back(mfifo[0].mis);
            void'(mfifo.pop_front());
         end
         if (s_resp && memq.size() != 0) begin
            r = memq.pop_front();
            if (!s_redir && r.epoch == epoch) mfifo.push_back('{r.addr, mem_word(r.addr), 1'b0});
         end
         if (s_redir) begin
            epoch++;
            mfifo.delete();
            next_req = {s_rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
            halted   = (s_rpc[1:0] != 2'b00);
            nop_pend = halted;
            nop_pc   = s_rpc;
`endif
         end else if (nop_pend) begin
            mfifo.push_back('{nop_pc, 32'h0000_0013, 1'b1});
            nop_pend = 1'b0;
         end
         if (s_fire) begin
            memq.push_back('{s_addr, epoch, cyc + lat - 1});
            fire_log.push_back(s_addr);
            next_req = next_req + 32'd4;
         end
      end
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (memq.size() != 0 && memq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(memq[0].addr);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cycles(1);
      redirect_valid = 1'b0;
   endtask

   initial begin : stim
      int p0, bf, bp;
      logic [31:0] rp;
      rst = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1;
      imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_instr", id_instr, 32'h0);
      check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
      @(posedge clk); #1;
      rst = 1'b0; id_ready = 1'b1;

      // Streaming with 1-cycle memory
      cycles(4);
      p0 = pop_log.size();
      cycles(8);
      check("throughput", 32'(pop_log.size() - p0), 32'd8);
      check("t1_fire0", fire_log[0], 32'h0);
      check("t1_fire1", fire_log[1], 32'h4);
      check("t1_fire2", fire_log[2], 32'h8);
      check("t1_pop0", pop_log[0], 32'h0);
      check("t1_pop1", pop_log[1], 32'h4);
      check("t1_pop2", pop_log[2], 32'h8);
      check("t1_instr0", pop_ilog[0], 32'hFFFF_0000);

      // Decode back-pressure
      id_ready = 1'b0;
      redirect(32'h0);
      bf = fire_log.size();
      cycles(10);
      check("bp_fires", 32'(fire_log.size() - bf), 32'd4);
      @(negedge clk);
      check("bp_req_valid_low", 32'(imem_req_valid), 32'd0);
      cycles(1);
      bp = pop_log.size();
      id_ready = 1'b1;
      cycles(8);
      check("bp_pop0", pop_log[bp], 32'h0);
      check("bp_pop1", pop_log[bp+1], 32'h4);
      check("bp_pop2", pop_log[bp+2], 32'h8);
      check("bp_pop3", pop_log[bp+3], 32'hC);
      check("bp_resume", fire_log[bf+4], 32'h10);

      // Redirect with 3-cycle memory and stale requests in flight
      lat = 3;
      cycles(8);
      bp = pop_log.size();
      redirect(32'h100);
      cycles(10);
      check("l3_pc", pop_log[bp], 32'h100);
      check("l3_instr", pop_ilog[bp], 32'hFFFF_0100);

      // Redirect coinciding with a response and a decode pop
      lat = 1;
      cycles(6);
      bp = pop_log.size();
      redirect(32'h40);
      @(negedge clk);
      check("same_cycle_empty", 32'(id_valid), 32'd0);
      cycles(6);
      check("same_cycle_pc", pop_log[bp], 32'h40);

      // Back-to-back redirects
      lat = 3;
      cycles(4);
      bp = pop_log.size();
      redirect(32'h300);
      redirect(32'h400);
      cycles(12);
      check("b2b_pc", pop_log[bp], 32'h400);

      // PC wrap
      lat = 1;
      cycles(4);
      bf = fire_log.size();
      bp = pop_log.size();
      redirect(32'hFFFF_FFF8);
      cycles(10);
      check("wrap_fire0", fire_log[bf], 32'hFFFF_FFF8);
      check("wrap_fire1", fire_log[bf+1], 32'hFFFF_FFFC);
      check("wrap_fire2", fire_log[bf+2], 32'h0);
      check("wrap_pop1", pop_log[bp+1], 32'hFFFF_FFFC);
      check("wrap_pop2", pop_log[bp+2], 32'h0);

`ifdef FETCH_MISALIGN_EN
      // Misaligned redirect yields a flagged NOP and halts fetch
      bf = fire_log.size();
      bp = pop_log.size();
      redirect(32'h102);
      cycles(6);
      check("mis_no_fetch", 32'(fire_log.size() - bf), 32'd0);
      check("mis_pc", pop_log[bp], 32'h102);
      check("mis_instr", pop_ilog[bp], 32'h13);
      check("mis_flag", 32'(pop_mlog[bp]), 32'd1);
      bf = fire_log.size();
      redirect(32'h200);
      cycles(8);
      check("mis_resume", fire_log[bf], 32'h200);
`else
      // Low redirect bits are ignored
      bp = pop_log.size();
      redirect(32'h206);
      cycles(6);
      check("lowbits_pc", pop_log[bp], 32'h204);
`endif

      // Randomized handshakes with occasional redirects
      for (int i = 0; i < 150; i++) begin
         imem_req_ready = 1'($urandom_range(0, 1));
         id_ready       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            lat = $urandom_range(1, 3);
            rp  = $urandom();
            rp  = rp & 32'h0000_FFFC;
            redirect(rp);
         end else begin
            cycles(1);
         end
      end
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      cycles(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
